ahb3lite_dma_arbiter: RTL

Command arbiter and sequencer in front of the AHB-Lite read master. It accepts DMA read commands (byte length, 32-bit address) from N_REQ requesters and grants them round-robin. It drives the master's start/command inputs and holds the command stable until the master reports done or a watchdog expires. While a command runs, it steers the master's read-data strobe to the owning requester.

---
 rtl/ahb3lite_dma_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb3lite_dma_arbiter.sv
// Round-robin arbiter that feeds DMA read commands to the AHB-Lite read master,
// holds each command until the master finishes or the watchdog fires, and routes read beats back.
module ahb3lite_dma_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [6*N_REQ-1:0]         req_len,
  input  logic [32*N_REQ-1:0]        req_addr,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           req_done,
  output logic [N_REQ-1:0]           req_err,
  output logic [N_REQ-1:0]           req_rdata_en,
  output logic                       o_SystemStart,
  output logic                       o_NewCommandOn,
  output logic [5:0]                 o_RCC_BUFFER_LENGTH,
  output logic [15:0]                o_RCC_DMA_ADDR_HIGH,
  output logic [15:0]                o_RCC_DMA_ADDR_LOW,
  input  logic                       Master_Done,
  input  logic                       HRDATA_En,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic [5:0]                 beat_cnt
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WDOG_LIM = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     winner;
  logic              found;
  logic [5:0]        sel_len;
  logic [31:0]       sel_addr;
  logic [5:0]        len_q;
  logic [31:0]       addr_q;
  logic [WW-1:0]     wdog;
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  rej_q;
  logic [N_REQ-1:0]  own_hot;
  logic [N_REQ-1:0]  win_hot;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    next_idx = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  assign own_hot = N_REQ'(1) << owner;
  assign win_hot = N_REQ'(1) << winner;

  // Two passes give the wrap-around scan: first requesters at or above ptr, then the rest.
  always_comb begin
    found    = 1'b0;
    winner   = ptr;
    sel_len  = '0;
    sel_addr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_valid[j] && (j >= int'(ptr))) begin
        found    = 1'b1;
        winner   = PW'(j);
        sel_len  = req_len[6*j +: 6];
        sel_addr = req_addr[32*j +: 32];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        winner   = PW'(j);
        sel_len  = req_len[6*j +: 6];
        sel_addr = req_addr[32*j +: 32];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found && (sel_len != 6'd0)) state_next = RUN;
      RUN:     if (Master_Done)                state_next = DONE;
               else if (wdog == WDOG_LIM)      state_next = ABORT;
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_SystemStart  = (state == RUN);
    o_NewCommandOn = (state == RUN);
    busy           = (state == RUN);
    req_ack        = ack_q;
    req_rdata_en   = ((state == RUN) && HRDATA_En) ? own_hot : '0;
    req_done       = (state == DONE) ? own_hot : '0;
    req_err        = rej_q | ((state == ABORT) ? own_hot : '0);
  end

  // Command latch, watchdog, beat counter and fairness pointer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr      <= '0;
      owner    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      wdog     <= '0;
      beat_cnt <= '0;
      ack_q    <= '0;
      rej_q    <= '0;
    end else begin
      ack_q <= '0;
      rej_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            len_q    <= sel_len;
            addr_q   <= sel_addr;
            owner    <= winner;
            ack_q    <= win_hot;
            beat_cnt <= '0;
            wdog     <= '0;
            if (sel_len == 6'd0) begin
              rej_q <= win_hot;
              ptr   <= next_idx(winner);
            end
          end
        end
        RUN: begin
          wdog <= wdog + 1'b1;
          if (HRDATA_En && (beat_cnt != 6'd63)) beat_cnt <= beat_cnt + 6'd1;
        end
        DONE, ABORT: ptr <= next_idx(owner);
        default: ;
      endcase
    end
  end

  assign o_RCC_BUFFER_LENGTH = len_q;
  assign o_RCC_DMA_ADDR_HIGH = addr_q[31:16];
  assign o_RCC_DMA_ADDR_LOW  = addr_q[15:0];

endmodule
